// File: rtl/key_scan_loader_pkg.sv
// Shared constants, key field layout and FSM state type for the serial key loader.
package key_pkg;
    localparam int KEY_W = 45;
    localparam int CRC_W = 8;
    localparam logic [CRC_W-1:0] CRC_POLY = 8'h07;

    // key_q layout: mux-lock selects in the low nibble, XOR key bits above
    localparam int P_LSB = 0;
    localparam int P_W   = 4;
    localparam int X_LSB = 4;
    localparam int X_W   = 41;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CHECK
    } state_t;
endpackage

// File: rtl/key_scan_loader_if.sv
// Serial key-load bus: frame control and data in, committed key and status out.
interface key_scan_loader_if;
    import key_pkg::*;

    logic             key_start;
    logic             key_valid;
    logic             key_sdi;
    logic [KEY_W-1:0] key_q;
    logic             key_loaded;
    logic             key_err;
    logic             busy;

    modport master (
        output key_start, key_valid, key_sdi,
        input  key_q, key_loaded, key_err, busy
    );

    modport slave (
        input  key_start, key_valid, key_sdi,
        output key_q, key_loaded, key_err, busy
    );
endinterface

// File: rtl/key_scan_loader_crc8.sv
// Bit-serial CRC-8 (MSB first, init 0, no reflection, no final XOR).
module crc8_serial
    import key_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             bit_in,
    output logic [CRC_W-1:0] crc
);
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            crc <= '0;
        end else if (en) begin
            crc <= {crc[CRC_W-2:0], 1'b0} ^ ((crc[CRC_W-1] ^ bit_in) ? CRC_POLY : '0);
        end
    end
endmodule

// File: rtl/key_scan_loader.sv
// Serial key loader: shifts in key + CRC-8, commits the key to a shadow register
// only when the received CRC matches the computed one.
module key_scan_loader
    import key_pkg::*;
#(
    parameter int TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst,
    key_scan_loader_if.slave  bus
);
    localparam int FRAME_W = KEY_W + CRC_W;
    localparam int BCNT_W  = $clog2(FRAME_W);
    localparam int GAP_W   = $clog2(TIMEOUT);
    localparam logic [BCNT_W-1:0] BCNT_KEY  = BCNT_W'(KEY_W);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(FRAME_W - 1);
    localparam logic [GAP_W-1:0]  GAP_MAX   = GAP_W'(TIMEOUT - 1);

    state_t             state_reg, state_next;
    logic [KEY_W-1:0]   shift_reg, shift_next;
    logic [CRC_W-1:0]   rx_crc_reg, rx_crc_next;
    logic [BCNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
    logic [GAP_W-1:0]   gap_cnt_reg, gap_cnt_next;
    logic [KEY_W-1:0]   key_q_reg, key_q_next;
    logic               loaded_reg, loaded_next;
    logic               err_reg, err_next;
    logic               busy_reg, busy_next;
    logic               crc_clr, crc_en;
    logic [CRC_W-1:0]   crc;

    crc8_serial u_crc (
        .clk    (clk),
        .rst    (rst),
        .clr    (crc_clr),
        .en     (crc_en),
        .bit_in (bus.key_sdi),
        .crc    (crc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            rx_crc_reg  <= '0;
            bit_cnt_reg <= '0;
            gap_cnt_reg <= '0;
            key_q_reg   <= '0;
            loaded_reg  <= 1'b0;
            err_reg     <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            rx_crc_reg  <= rx_crc_next;
            bit_cnt_reg <= bit_cnt_next;
            gap_cnt_reg <= gap_cnt_next;
            key_q_reg   <= key_q_next;
            loaded_reg  <= loaded_next;
            err_reg     <= err_next;
            busy_reg    <= busy_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        rx_crc_next  = rx_crc_reg;
        bit_cnt_next = bit_cnt_reg;
        gap_cnt_next = gap_cnt_reg;
        key_q_next   = key_q_reg;
        loaded_next  = loaded_reg;
        err_next     = err_reg;
        crc_clr      = 1'b0;
        crc_en       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.key_start) begin
                    state_next   = SHIFT;
                    bit_cnt_next = '0;
                    gap_cnt_next = '0;
                    err_next     = 1'b0;
                    crc_clr      = 1'b1;
                end
            end
            SHIFT: begin
                // start wins over a coincident data bit, which is dropped
                if (bus.key_start) begin
                    bit_cnt_next = '0;
                    gap_cnt_next = '0;
                    err_next     = 1'b0;
                    crc_clr      = 1'b1;
                end else if (bus.key_valid) begin
                    if (bit_cnt_reg < BCNT_KEY) begin
                        shift_next = {shift_reg[KEY_W-2:0], bus.key_sdi};
                        crc_en     = 1'b1;
                    end else begin
                        rx_crc_next = {rx_crc_reg[CRC_W-2:0], bus.key_sdi};
                    end
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                    gap_cnt_next = '0;
                    if (bit_cnt_reg == BCNT_LAST) begin
                        state_next = CHECK;
                    end
                end else if (gap_cnt_reg == GAP_MAX) begin
                    state_next = IDLE;
                    err_next   = 1'b1;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 1'b1;
                end
            end
            CHECK: begin
                if (crc == rx_crc_reg) begin
                    key_q_next  = shift_reg;
                    loaded_next = 1'b1;
                end else begin
                    err_next = 1'b1;
                end
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy_next = (state_next != IDLE);

    assign bus.key_q      = key_q_reg;
    assign bus.key_loaded = loaded_reg;
    assign bus.key_err    = err_reg;
    assign bus.busy       = busy_reg;
endmodule

// File: tb/tb_key_scan_loader.sv
// Directed bench for key_scan_loader: good/bad frames, timeout, restart and reset mid-frame.
module tb_key_scan_loader;
    import key_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    key_scan_loader_if bus ();

    key_scan_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse(input logic v, input logic d);
        bus.key_start = 1'b1;
        bus.key_valid = v;
        bus.key_sdi   = d;
        tick();
        bus.key_start = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_sdi   = 1'b0;
    endtask

    task automatic shift_bits(input logic [63:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bus.key_valid = 1'b1;
            bus.key_sdi   = val[i];
            tick();
        end
        bus.key_valid = 1'b0;
        bus.key_sdi   = 1'b0;
    endtask

    // Full frame; leaves time one edge after the CHECK cycle, when outputs have updated.
    task automatic send_frame(input string tag, input logic [63:0] key, input logic [7:0] crc);
        start_pulse(1'b0, 1'b0);
        shift_bits(key, KEY_W);
        shift_bits({56'h0, crc}, CRC_W);
        check({tag, ".busy_check"}, {63'h0, bus.busy}, 64'h1);
        tick();
        check({tag, ".busy_done"}, {63'h0, bus.busy}, 64'h0);
    endtask

    initial begin
        logic [63:0] key_v;
        bus.key_start = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_sdi   = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check("reset.key_q",  {19'h0, bus.key_q}, 64'h0);
        check("reset.loaded", {63'h0, bus.key_loaded}, 64'h0);
        check("reset.err",    {63'h0, bus.key_err}, 64'h0);
        check("reset.busy",   {63'h0, bus.busy}, 64'h0);

        // key_valid while IDLE must not start anything
        bus.key_valid = 1'b1;
        bus.key_sdi   = 1'b1;
        tick();
        tick();
        bus.key_valid = 1'b0;
        check("idle_valid.busy", {63'h0, bus.busy}, 64'h0);

        // 1. all-zero frame
        send_frame("t1", 64'h0, 8'h00);
        check("t1.key_q",  {19'h0, bus.key_q}, 64'h0);
        check("t1.loaded", {63'h0, bus.key_loaded}, 64'h1);
        check("t1.err",    {63'h0, bus.key_err}, 64'h0);

        // 2. key 45'h1, CRC 07
        send_frame("t2", 64'h1, 8'h07);
        check("t2.key_q",  {19'h0, bus.key_q}, 64'h1);
        check("t2.p1",     {63'h0, bus.key_q[P_LSB]}, 64'h1);
        check("t2.loaded", {63'h0, bus.key_loaded}, 64'h1);

        // 3. bad CRC: old key held
        send_frame("t3", 64'h0, 8'h01);
        check("t3.err",    {63'h0, bus.key_err}, 64'h1);
        check("t3.key_q",  {19'h0, bus.key_q}, 64'h1);
        check("t3.loaded", {63'h0, bus.key_loaded}, 64'h1);

        // next start clears the sticky error
        start_pulse(1'b0, 1'b0);
        check("start_clr.err",  {63'h0, bus.key_err}, 64'h0);
        check("start_clr.busy", {63'h0, bus.busy}, 64'h1);

        // key 45'h3: CRC 07 after first '1', then (07<<1)^07 = 09
        shift_bits(64'h3, KEY_W);
        shift_bits(64'h09, CRC_W);
        tick();
        check("t3b.key_q", {19'h0, bus.key_q}, 64'h3);
        check("t3b.err",   {63'h0, bus.key_err}, 64'h0);

        // key 45'h2: CRC (07<<1) = 0E
        send_frame("t3c", 64'h2, 8'h0E);
        check("t3c.key_q", {19'h0, bus.key_q}, 64'h2);

        // 4. timeout after 20 bits: still busy after 255 idle cycles, IDLE after 256
        start_pulse(1'b0, 1'b0);
        shift_bits(64'hFFFFF, 20);
        for (int i = 0; i < 255; i++) tick();
        check("t4.busy_255", {63'h0, bus.busy}, 64'h1);
        check("t4.err_255",  {63'h0, bus.key_err}, 64'h0);
        tick();
        check("t4.busy", {63'h0, bus.busy}, 64'h0);
        check("t4.err",  {63'h0, bus.key_err}, 64'h1);
        check("t4.key_q", {19'h0, bus.key_q}, 64'h2);

        // 5. restart mid-frame, coincident valid bit discarded
        start_pulse(1'b0, 1'b0);
        shift_bits(64'h3FFFFFFF, 30);
        start_pulse(1'b1, 1'b1);
        check("t5.err_clr", {63'h0, bus.key_err}, 64'h0);
        shift_bits(64'h1, KEY_W);
        shift_bits(64'h07, CRC_W);
        tick();
        check("t5.key_q", {19'h0, bus.key_q}, 64'h1);
        check("t5.err",   {63'h0, bus.key_err}, 64'h0);
        check("t5.busy",  {63'h0, bus.busy}, 64'h0);

        // 6. reset mid-frame
        start_pulse(1'b0, 1'b0);
        shift_bits(64'h3FF, 10);
        check("t6.busy_pre", {63'h0, bus.busy}, 64'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6.key_q",  {19'h0, bus.key_q}, 64'h0);
        check("t6.loaded", {63'h0, bus.key_loaded}, 64'h0);
        check("t6.err",    {63'h0, bus.key_err}, 64'h0);
        check("t6.busy",   {63'h0, bus.busy}, 64'h0);
        key_v = 64'h1;
        send_frame("t6b", key_v, 8'h07);
        check("t6b.key_q",  {19'h0, bus.key_q}, 64'h1);
        check("t6b.loaded", {63'h0, bus.key_loaded}, 64'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
